// File: rtl/calc_core_param.sv
// W-bit accumulator calculator with status flags and a drop-oldest LIFO undo history.
// Define CALC_MUL_EN to build the iterative shift-add multiplier (op 7); otherwise op 7 is rejected.
module calc_core_param #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W-1:0]               num_in,
    input  logic [2:0]                 op_in,
    input  logic                       enter,
    input  logic                       undo,
    output logic [W-1:0]               num_out,
    output logic                       flag_zero,
    output logic                       flag_carry,
    output logic                       flag_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] depth_cnt
);
    localparam int DCW = $clog2(DEPTH + 1);

    // Handshake: enter/undo are level inputs; a request is one 0->1 transition seen on
    // consecutive clocks. Requests arriving while busy are dropped; enter beats undo.
    logic           r_enter_q, r_undo_q;
    logic [W-1:0]   r_acc;
    logic           r_zero, r_carry, r_err;
    logic [DCW-1:0] r_depth;
    logic [W-1:0]   r_hist [DEPTH];

    logic           w_enter_edge, w_undo_edge, w_busy, w_accept, w_is_mul;
    logic           w_push, w_pop, w_mul_done, w_mul_ovf;
    logic [W-1:0]   w_mul_res;
    logic [W-1:0]   w_result;
    logic           w_carry;
    logic [W:0]     w_sum;

    assign w_enter_edge = enter & ~r_enter_q;
    assign w_undo_edge  = undo & ~r_undo_q;
    assign w_is_mul     = (op_in == 3'd7);
    assign w_accept     = ~w_busy & w_enter_edge;
    assign w_pop        = ~w_busy & ~w_enter_edge & w_undo_edge & (r_depth != '0);

`ifdef CALC_MUL_EN
    // The FSM state is the busy output itself.
    typedef enum logic {S_IDLE, S_MUL} state_t;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    state_t           r_state, w_state_nxt;
    logic [2*W-1:0]   r_mcand, r_prod, w_prod_nxt;
    logic [W-1:0]     r_mplier;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == CW'(W - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy     = (r_state == S_MUL);
    assign w_mul_done = w_busy && (r_cnt == CW'(W - 1));
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_res  = w_prod_nxt[W-1:0];
    assign w_mul_ovf  = |w_prod_nxt[2*W-1:W];
    assign w_push     = w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= {{W{1'b0}}, r_acc};
            r_prod   <= '0;
            r_mplier <= num_in;
            r_cnt    <= '0;
        end else if (w_busy) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    assign w_busy     = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
    assign w_mul_ovf  = 1'b0;
    assign w_push     = w_accept & ~w_is_mul;
`endif

    assign w_sum = {1'b0, r_acc} + {1'b0, num_in};

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (op_in)
            3'd0: begin w_result = w_sum[W-1:0]; w_carry = w_sum[W]; end
            3'd1: begin w_result = r_acc - num_in; w_carry = (num_in > r_acc); end
            3'd2: w_result = r_acc | num_in;
            3'd3: w_result = {{(W-1){1'b0}}, (r_acc == num_in)};
            3'd4: w_result = r_acc & num_in;
            3'd5: w_result = r_acc ^ num_in;
            3'd6: w_result = (num_in >= W'(W)) ? '0 : (r_acc << num_in);
            default: w_result = '0;
        endcase
    end

    // Index 0 is the newest entry; pushing shifts the oldest out of the far end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        end else if (w_push) begin
            r_hist[0] <= r_acc;
            for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
        end else if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) r_hist[i] <= r_hist[i+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enter_q <= 1'b0;
            r_undo_q  <= 1'b0;
            r_acc     <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_err     <= 1'b0;
            r_depth   <= '0;
        end else begin
            r_enter_q <= enter;
            r_undo_q  <= undo;
            if (w_push && r_depth != DCW'(DEPTH)) r_depth <= r_depth + 1'b1;
            else if (w_pop)                       r_depth <= r_depth - 1'b1;

            if (w_mul_done) begin
                r_acc   <= w_mul_res;
                r_zero  <= (w_mul_res == '0);
                r_carry <= w_mul_ovf;
                r_err   <= 1'b0;
            end else if (w_accept && !w_is_mul) begin
                r_acc   <= w_result;
                r_zero  <= (w_result == '0);
                r_carry <= w_carry;
                r_err   <= 1'b0;
            end else if (w_accept && !w_push) begin
                r_err   <= 1'b1;
            end else if (w_pop) begin
                r_acc   <= r_hist[0];
                r_zero  <= (r_hist[0] == '0);
                r_carry <= 1'b0;
                r_err   <= 1'b0;
            end else if (!w_busy && !w_enter_edge && w_undo_edge) begin
                r_err   <= 1'b1;
            end
        end
    end

    assign num_out    = r_acc;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign flag_err   = r_err;
    assign busy       = w_busy;
    assign depth_cnt  = r_depth;

endmodule

// File: tb/tb_calc_core_param.sv
// Self-checking bench for calc_core_param (W=8, DEPTH=4): reference model feeds an expected
// queue; each request's outcome is popped and compared once the DUT has settled.
module tb_calc_core_param;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] num_in = '0;
    logic [2:0]   op_in = '0;
    logic         enter = 1'b0;
    logic         undo = 1'b0;
    logic [W-1:0] num_out;
    logic         flag_zero, flag_carry, flag_err, busy;
    logic [2:0]   depth_cnt;

    calc_core_param #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .num_in(num_in), .op_in(op_in),
        .enter(enter), .undo(undo), .num_out(num_out), .flag_zero(flag_zero),
        .flag_carry(flag_carry), .flag_err(flag_err), .busy(busy), .depth_cnt(depth_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expected entry: {acc[7:0], zero, carry, err, depth[2:0]}
    logic [13:0] exp_q[$];
    int          m_acc, m_zero, m_carry, m_err;
    int          m_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_push_exp();
        logic [13:0] e;
        e = {m_acc[7:0], m_zero[0], m_carry[0], m_err[0], 3'(m_hist.size())};
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_acc = 0; m_zero = 0; m_carry = 0; m_err = 0;
        m_hist.delete();
    endtask

    task automatic model_enter(input int op, input int num);
        int r, c, p;
        r = 0; c = 0;
`ifndef CALC_MUL_EN
        if (op == 7) begin
            m_err = 1;
            model_push_exp();
            return;
        end
`endif
        case (op)
            0: begin r = (m_acc + num) % 256; c = (m_acc + num) > 255; end
            1: begin r = (m_acc - num + 256) % 256; c = num > m_acc; end
            2: r = m_acc | num;
            3: r = (m_acc == num) ? 1 : 0;
            4: r = m_acc & num;
            5: r = m_acc ^ num;
            6: r = (num >= W) ? 0 : ((m_acc << num) % 256);
            default: begin p = m_acc * num; r = p % 256; c = (p >= 256); end
        endcase
        m_hist.push_front(m_acc);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
        m_acc = r; m_carry = c; m_zero = (r == 0); m_err = 0;
        model_push_exp();
    endtask

    task automatic model_undo();
        if (m_hist.size() > 0) begin
            m_acc = m_hist.pop_front();
            m_zero = (m_acc == 0); m_carry = 0; m_err = 0;
        end else begin
            m_err = 1;
        end
        model_push_exp();
    endtask

    task automatic sb_compare(input string tag);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_acc"},   num_out,    e[13:6]);
        check({tag, "_zero"},  flag_zero,  e[5]);
        check({tag, "_carry"}, flag_carry, e[4]);
        check({tag, "_err"},   flag_err,   e[3]);
        check({tag, "_depth"}, depth_cnt,  e[2:0]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; enter = 1'b0; undo = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_acc", num_out, 0);
        check("rst_flags", {flag_zero, flag_carry, flag_err}, 0);
        check("rst_busy", busy, 0);
        check("rst_depth", depth_cnt, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_enter(input string tag, input logic [2:0] op, input logic [7:0] num);
        logic [7:0] old;
        int n;
        old = num_out;
        model_enter(int'(op), int'(num));
        @(negedge clk);
        op_in = op; num_in = num; enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
`ifdef CALC_MUL_EN
        if (op == 3'd7) begin
            n = 0;
            while (busy && n < 40) begin
                check({tag, "_hold"}, num_out, old);
                if (n == 2) enter = 1'b1;
                if (n == 3) enter = 1'b0;
                n++;
                @(negedge clk);
            end
            check({tag, "_busy_cycles"}, n, W);
        end
`endif
        check({tag, "_idle"}, busy, 0);
        sb_compare(tag);
    endtask

    task automatic do_undo(input string tag);
        model_undo();
        @(negedge clk);
        undo = 1'b1;
        @(negedge clk);
        undo = 1'b0;
        sb_compare(tag);
    endtask

    task automatic do_both(input string tag, input logic [2:0] op, input logic [7:0] num);
        model_enter(int'(op), int'(num));
        @(negedge clk);
        op_in = op; num_in = num; enter = 1'b1; undo = 1'b1;
        @(negedge clk);
        enter = 1'b0; undo = 1'b0;
        @(negedge clk);
        sb_compare(tag);
    endtask

    task automatic do_hold(input string tag, input logic [7:0] num);
        model_enter(0, int'(num));
        @(negedge clk);
        op_in = 3'd0; num_in = num; enter = 1'b1;
        repeat (6) @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        sb_compare(tag);
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] rnum;

        model_reset();
        apply_reset();

        do_enter("add200", 3'd0, 8'd200);
        do_enter("add100", 3'd0, 8'd100);
        do_enter("sub44",  3'd1, 8'd44);
        do_enter("sub1",   3'd1, 8'd1);
        do_enter("eq255",  3'd3, 8'd255);
        do_hold("hold_add1", 8'd1);

        do_enter("to_zero", 3'd1, 8'd2);
        for (int i = 1; i <= 5; i++) do_enter("add_seq", 3'd0, 8'(i));
        for (int i = 0; i < 5; i++) do_undo("undo_seq");
        do_both("both_edges", 3'd0, 8'd3);

        do_enter("or",    3'd2, 8'hF0);
        do_enter("and",   3'd4, 8'h3C);
        do_enter("xor",   3'd5, 8'hFF);
        do_enter("shl2",  3'd6, 8'd2);
        do_enter("shl9",  3'd6, 8'd9);
        do_enter("add_a", 3'd0, 8'd77);
        do_enter("shl8",  3'd6, 8'd8);

        for (int i = 0; i < 12; i++) begin
            rop  = 3'($urandom_range(0, 6));
            rnum = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) do_undo("rnd_undo");
            else do_enter("rnd_op", rop, rnum);
        end

        apply_reset();
        do_enter("add13", 3'd0, 8'd13);
        do_enter("mul11", 3'd7, 8'd11);
`ifdef CALC_MUL_EN
        do_enter("sub123", 3'd1, 8'd123);
        do_enter("mul20",  3'd7, 8'd20);
`endif

        // Asynchronous reset away from any clock edge, mid-multiply when it exists.
        do_enter("pre_rst", 3'd0, 8'd9);
        @(negedge clk);
        op_in = 3'd7; num_in = 8'd5; enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_acc", num_out, 0);
        check("arst_flags", {flag_zero, flag_carry, flag_err}, 0);
        check("arst_busy", busy, 0);
        check("arst_depth", depth_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_enter("add7", 3'd0, 8'd7);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
- Parametrised successor to the team's 8-bit calculator chip: a W-bit accumulator calculator with an extended op set, status flags, and an undo history stack of configurable depth.
- Optional multi-cycle iterative multiplier.
- Sits behind the Tiny Tapeout wrapper: ui_in feeds num_in; uio_in carries op_in, enter and undo.
- Enter and undo are rising-edge triggered from slow human-driven inputs; each edge commits or reverts exactly once.

Parameters:
- W, 8, accumulator/operand width in bits (W >= 2).
- DEPTH, 4, undo history entries (DEPTH >= 1).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- num_in  input  W  operand.
- op_in  input  3  opcode: 0 ADD, 1 SUB, 2 OR, 3 EQ, 4 AND, 5 XOR, 6 SHL, 7 MUL.
- enter  input  1  level input; rising edge commits op_in/num_in.
- undo  input  1  level input; rising edge restores the previous accumulator.
- num_out  output  W  accumulator value.
- flag_zero  output  1  last committed result == 0.
- flag_carry  output  1  ADD carry-out, SUB borrow, MUL overflow; otherwise 0.
- flag_err  output  1  last request was rejected.
- busy  output  1  multiply in progress.
- depth_cnt  output  $clog2(DEPTH+1)  valid history entries.

Behaviour:
- Reset (rst_n low, async):
  - acc, flags, busy, depth_cnt = 0.
  - Edge-detect registers = 0.
  - Any in-progress MUL is aborted.
- Edge detection:
  - enter_q and undo_q register enter and undo every cycle, including while busy.
  - Edge = in & ~in_q.
  - An edge while busy is dropped, not queued.
- Priority: enter edge and undo edge in the same cycle → enter wins; undo is dropped.
- Single-cycle commit (ops 0–6), on an enter edge with busy = 0:
  - Push acc onto history. If depth_cnt == DEPTH, discard the oldest entry and leave depth_cnt at DEPTH; else depth_cnt += 1.
  - acc <= result on the same clock edge, so num_out is valid the cycle after the edge is sampled.
  - Flags update on the same edge; flag_err <= 0.
- Arithmetic (mod 2^W):
  - ADD: carry = bit W of the (W+1)-bit sum.
  - SUB: acc - num_in; carry = 1 iff num_in > acc (unsigned borrow).
  - OR/AND/XOR: bitwise; carry = 0.
  - EQ: result = 1 if acc == num_in, else 0; carry = 0.
  - SHL: acc << num_in (full num_in value); num_in >= W gives 0; carry = 0.
  - flag_zero = (result == 0) for all ops.
- MUL (op 7, enter edge, busy = 0):
  - Push history as above. Capture multiplicand = acc, multiplier = num_in.
  - busy = 1 for exactly W cycles, starting the cycle after the edge. Shift-add one bit per cycle into a 2W-bit product.
  - On the final cycle: acc <= product[W-1:0]; carry = |product[2W-1:W]; zero per result; err = 0; busy falls the next cycle.
  - num_out holds the old acc while busy.
- Undo edge, busy = 0:
  - depth_cnt > 0: acc <= newest entry; depth_cnt -= 1; zero recomputed; carry = 0; err = 0.
  - depth_cnt == 0: acc unchanged; flag_err <= 1; other flags held.
- flag_err is held until the next accepted commit or successful undo.
- History is a LIFO: newest entry on top; drop-oldest on overflow.

Optional Feature:
- CALC_MUL_EN defined: iterative multiplier and busy logic are synthesised as above.
- CALC_MUL_EN undefined:
  - op 7 on an enter edge is rejected: acc, history and depth_cnt unchanged; flag_err <= 1.
  - busy is tied to 0.
  - No multiplier registers are synthesised.

Test Plan (W=8, DEPTH=4):
- Reset, then enter ADD 200, then enter ADD 100 → num_out 200, then 44; carry=1; zero=0; depth_cnt=2.
- Hold enter high 6 cycles with ADD 1 → exactly one increment; no further commit until enter drops and rises again.
- acc=44: SUB 44 → 0, zero=1, carry=0. Then SUB 1 → 255, carry=1. Then EQ 255 → 1.
- Five commits ADD 1..5 from 0 (acc 1, 3, 6, 10, 15), then five undos:
  - First four undos → 10, 6, 3, 1; depth_cnt=0.
  - Fifth undo → acc stays 1, err=1.
  - Enter and undo edges in the same cycle → enter applied, undo ignored.
- (CALC_MUL_EN) acc=13, MUL 11:
  - busy=1 for 8 cycles; enter pulse during busy ignored; result 143, carry=0.
  - Then acc=20, MUL 20 → 144, carry=1.
  - Without the macro: MUL leaves acc unchanged, err=1, busy=0.
- Assert rst_n low mid-MUL (cycle 3 of busy), asynchronously to clk → num_out, flags, busy, depth_cnt all 0 immediately; after release, ADD 7 → 7.
